// File: rtl/sd_defines.sv
// Shared definitions for the SD data-line transfer sequencer: engine command
// encodings, error bit positions and the one-hot sequencer state encoding.
package sd_defines;

  localparam logic [1:0] SD_DAT_CMD_NONE  = 2'b00;
  localparam logic [1:0] SD_DAT_CMD_WRITE = 2'b01;
  localparam logic [1:0] SD_DAT_CMD_READ  = 2'b10;
  localparam logic [1:0] SD_DAT_CMD_STOP  = 2'b11;

  localparam int ERR_CRC          = 0;
  localparam int ERR_TIMEOUT      = 1;
  localparam int ERR_ABORTED      = 2;
  localparam int ERR_REQ_CONFLICT = 3;

  typedef enum logic [6:0] {
    S_IDLE    = 7'b0000001,
    S_PREFILL = 7'b0000010,
    S_START   = 7'b0000100,
    S_ACTIVE  = 7'b0001000,
    S_ACK     = 7'b0010000,
    S_ABORT   = 7'b0100000,
    S_DONE    = 7'b1000000
  } xfer_state_t;

endpackage

// File: rtl/sd_xfer_watchdog.sv
// Transfer watchdog: cycle counter and limit compare, built only when
// SD_DATA_XFER_TIMEOUT_EN is defined.
`ifdef SD_DATA_XFER_TIMEOUT_EN
module sd_xfer_watchdog #(
  parameter int TIMEOUT_W = 24
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 i_clear,
  input  logic                 i_count,
  input  logic [TIMEOUT_W-1:0] i_timeout,
  output logic                 o_hit
);

  logic [TIMEOUT_W-1:0] r_cnt;
  logic [TIMEOUT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  // Hit on the cycle whose increment would reach the limit; a zero limit disables.
  assign o_hit = i_count && (i_timeout != {TIMEOUT_W{1'b0}}) && (w_cnt_inc == i_timeout);

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {TIMEOUT_W{1'b0}};
    end else if (i_clear) begin
      r_cnt <= {TIMEOUT_W{1'b0}};
    end else if (i_count) begin
      r_cnt <= w_cnt_inc;
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule
`endif

// File: rtl/sd_data_xfer_ctrl.sv
// SD data-line transfer sequencer: issues start_dat, tracks completion and
// holds ack_transfer. Optional watchdog under SD_DATA_XFER_TIMEOUT_EN.
module sd_data_xfer_ctrl
  import sd_defines::*;
#(
  parameter int TIMEOUT_W = 24
) (
  input  logic                 sd_clk,
  input  logic                 rst,
  input  logic                 i_tx_req,
  input  logic                 i_rx_req,
  input  logic                 i_abort_req,
  input  logic [TIMEOUT_W-1:0] i_timeout,
  input  logic                 i_tx_fifo_empty,
  input  logic                 i_busy_n,
  input  logic                 i_transm_complete,
  input  logic                 i_crc_ok,
  input  logic                 i_err_clr,
  output logic [1:0]           o_start_dat,
  output logic                 o_ack_transfer,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [3:0]           o_err
);

  xfer_state_t r_state;
  xfer_state_t w_state_next;
  logic        r_dir_rd;
  logic        w_dir_rd_next;
  logic [3:0]  w_err_set;
  logic        w_wd_hit;
  logic        w_wd_clear;
  logic        w_wd_count;
  logic [1:0]  r_start_dat;
  logic        r_ack_transfer;
  logic        r_busy;
  logic        r_done;
  logic [3:0]  r_err;

  assign w_wd_count = (r_state != S_IDLE) && (r_state != S_DONE);

`ifdef SD_DATA_XFER_TIMEOUT_EN
  sd_xfer_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
    .sd_clk    (sd_clk),
    .rst       (rst),
    .i_clear   (w_wd_clear),
    .i_count   (w_wd_count),
    .i_timeout (i_timeout),
    .o_hit     (w_wd_hit)
  );
`else
  logic w_unused_wd;
  assign w_wd_hit    = 1'b0;
  assign w_unused_wd = ^{i_timeout, w_wd_clear, w_wd_count};
`endif

  // Next-state and error-set decode; abort outranks watchdog and completion.
  always_comb begin
    w_state_next  = r_state;
    w_dir_rd_next = r_dir_rd;
    w_err_set     = 4'b0000;
    w_wd_clear    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_tx_req && i_rx_req) begin
          w_err_set[ERR_REQ_CONFLICT] = 1'b1;
        end else if (i_tx_req) begin
          w_state_next  = S_PREFILL;
          w_dir_rd_next = 1'b0;
          w_wd_clear    = 1'b1;
        end else if (i_rx_req) begin
          w_state_next  = S_START;
          w_dir_rd_next = 1'b1;
          w_wd_clear    = 1'b1;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_PREFILL: begin
        if (i_abort_req) begin
          w_state_next           = S_ABORT;
          w_err_set[ERR_ABORTED] = 1'b1;
          w_wd_clear             = 1'b1;
        end else if (w_wd_hit) begin
          w_state_next           = S_ABORT;
          w_err_set[ERR_TIMEOUT] = 1'b1;
          w_wd_clear             = 1'b1;
        end else if (!i_tx_fifo_empty) begin
          w_state_next = S_START;
        end else begin
          w_state_next = S_PREFILL;
        end
      end
      S_START: begin
        if (i_abort_req) begin
          w_state_next           = S_ABORT;
          w_err_set[ERR_ABORTED] = 1'b1;
          w_wd_clear             = 1'b1;
        end else if (w_wd_hit) begin
          w_state_next           = S_ABORT;
          w_err_set[ERR_TIMEOUT] = 1'b1;
          w_wd_clear             = 1'b1;
        end else begin
          w_state_next = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (i_abort_req) begin
          w_state_next           = S_ABORT;
          w_err_set[ERR_ABORTED] = 1'b1;
          w_wd_clear             = 1'b1;
        end else if (w_wd_hit) begin
          w_state_next           = S_ABORT;
          w_err_set[ERR_TIMEOUT] = 1'b1;
          w_wd_clear             = 1'b1;
        end else if (i_transm_complete) begin
          w_state_next       = S_ACK;
          w_err_set[ERR_CRC] = ~i_crc_ok;
        end else begin
          w_state_next = S_ACTIVE;
        end
      end
      S_ACK: begin
        if (i_busy_n) begin
          w_state_next = S_DONE;
        end else if (w_wd_hit) begin
          w_state_next           = S_ABORT;
          w_err_set[ERR_TIMEOUT] = 1'b1;
          w_wd_clear             = 1'b1;
        end else begin
          w_state_next = S_ACK;
        end
      end
      S_ABORT: begin
        if (i_busy_n || w_wd_hit) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_ABORT;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    w_err_set[ERR_REQ_CONFLICT] = w_err_set[ERR_REQ_CONFLICT] | (r_busy & (i_tx_req | i_rx_req));
  end

  // State and registered outputs, all derived from the upcoming state.
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_dir_rd       <= 1'b0;
      r_start_dat    <= SD_DAT_CMD_NONE;
      r_ack_transfer <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 4'b0000;
    end else begin
      r_state  <= w_state_next;
      r_dir_rd <= w_dir_rd_next;
      case (w_state_next)
        S_START: r_start_dat <= w_dir_rd_next ? SD_DAT_CMD_READ : SD_DAT_CMD_WRITE;
        S_ABORT: r_start_dat <= SD_DAT_CMD_STOP;
        default: r_start_dat <= SD_DAT_CMD_NONE;
      endcase
      r_ack_transfer <= (w_state_next == S_ACK) || (w_state_next == S_ABORT);
      r_busy         <= (w_state_next != S_IDLE) && (w_state_next != S_DONE);
      r_done         <= (w_state_next == S_DONE);
      r_err          <= (r_err & {4{~i_err_clr}}) | w_err_set;
    end
  end

  assign o_start_dat    = r_start_dat;
  assign o_ack_transfer = r_ack_transfer;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_err          = r_err;

endmodule

// File: tb/tb_sd_data_xfer_ctrl.sv
// Self-checking bench for sd_data_xfer_ctrl: directed scenarios plus random
// transfers scored against an event-timeline model of each transfer.
module tb_sd_data_xfer_ctrl;

  logic        sd_clk = 1'b0;
  logic        rst;
  logic        tx_req, rx_req, abort_req, tx_fifo_empty, busy_n;
  logic        transm_complete, crc_ok, err_clr;
  logic [23:0] timeout;
  logic [1:0]  start_dat;
  logic        ack_transfer, busy, done;
  logic [3:0]  err;

  int          n_checks = 0;
  int          n_err = 0;
  logic [3:0]  err_model = 4'b0000;

  sd_data_xfer_ctrl #(.TIMEOUT_W(24)) dut (
    .sd_clk            (sd_clk),
    .rst               (rst),
    .i_tx_req          (tx_req),
    .i_rx_req          (rx_req),
    .i_abort_req       (abort_req),
    .i_timeout         (timeout),
    .i_tx_fifo_empty   (tx_fifo_empty),
    .i_busy_n          (busy_n),
    .i_transm_complete (transm_complete),
    .i_crc_ok          (crc_ok),
    .i_err_clr         (err_clr),
    .o_start_dat       (start_dat),
    .o_ack_transfer    (ack_transfer),
    .o_busy            (busy),
    .o_done            (done),
    .o_err             (err)
  );

  always #5 sd_clk = ~sd_clk;

  task automatic chk(input string tag, input int t, input logic [3:0] obs, input logic [3:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input int t, input logic [1:0] e_sd, input logic e_ack,
                         input logic e_busy, input logic e_done, input logic [3:0] e_err);
    chk({tag, ".start_dat"}, t, {2'b00, start_dat}, {2'b00, e_sd});
    chk({tag, ".ack"}, t, {3'b000, ack_transfer}, {3'b000, e_ack});
    chk({tag, ".busy"}, t, {3'b000, busy}, {3'b000, e_busy});
    chk({tag, ".done"}, t, {3'b000, done}, {3'b000, e_done});
    chk({tag, ".err"}, t, err, e_err);
  endtask

  task automatic drive_idle();
    tx_req = 1'b0; rx_req = 1'b0; abort_req = 1'b0; tx_fifo_empty = 1'b1;
    busy_n = 1'b0; transm_complete = 1'b0; crc_ok = 1'b1; err_clr = 1'b0;
  endtask

  task automatic step();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge sd_clk);
    chk("err_clr", 0, err, 4'b0000);
    step();
    err_model = 4'b0000;
  endtask

  // One transfer, request at relative cycle 0. fd: extra empty-FIFO cycles in
  // PREFILL, al: ACTIVE cycles before completion, ad: extra cycles before busy_n,
  // a: abort cycle (-1 none), stray: cycle of a request while busy (-1 none).
  task automatic run_xfer(input string tag, input bit rd, input int fd, input int al, input bit crc,
                          input int ad, input int a, input int stray);
    int s, m, k, b, fin, quiet;
    logic [1:0] e_sd;
    logic [3:0] e_err;
    s = rd ? 1 : fd + 2;
    m = s + 1 + al;
    k = m + 1 + ad;
    b = a + 1 + ad;
    fin = (a >= 0) ? b : k;
    quiet = (a >= 0) ? a : m;
    e_err = err_model;
    for (int t = 0; t <= fin + 2; t++) begin
      tx_req = (t == 0) && !rd;
      rx_req = ((t == 0) && rd) || (t == stray);
      tx_fifo_empty = rd ? ($urandom_range(1, 0) == 1) : (t < s - 1);
      abort_req = (t == a) || (a < 0 && t > m && t <= k + 1 && $urandom_range(1, 0) == 1);
      transm_complete = (t == m) && (a < 0 || a == m);
      crc_ok = (t == m) ? crc : ($urandom_range(1, 0) == 1);
      busy_n = (t == fin) ? 1'b1 : ((t < quiet) ? ($urandom_range(1, 0) == 1) : 1'b0);
      err_clr = 1'b0;
      if (a >= 0 && t >= a + 1 && t <= b) e_sd = 2'b11;
      else if (t == s && (a < 0 || s <= a)) e_sd = rd ? 2'b10 : 2'b01;
      else e_sd = 2'b00;
      e_err = err_model;
      if (a < 0 && !crc && t >= m + 1) e_err[0] = 1'b1;
      if (a >= 0 && t >= a + 1) e_err[2] = 1'b1;
      if (stray >= 1 && t >= stray + 1) e_err[3] = 1'b1;
      @(negedge sd_clk);
      chk_all(tag, t, e_sd,
              (a >= 0) ? (t >= a + 1 && t <= b) : (t >= m + 1 && t <= k),
              (t >= 1 && t <= fin), (t == fin + 1), e_err);
      step();
    end
    err_model = e_err;
    drive_idle();
  endtask

  initial begin
    int rd, fd, al, ad, a, stray, s, m, fin;
    rst = 1'b1;
    timeout = 24'd0;
    drive_idle();
    #12;
    chk_all("reset", 0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000);
    @(negedge sd_clk);
    rst = 1'b0;
    step();

    // Read with good CRC: request at 10, complete at 50, busy_n at 54.
    run_xfer("rd_good", 1'b1, 0, 38, 1'b1, 3, -1, -1);
    // Write with FIFO filling 10 cycles after request, bad CRC.
    run_xfer("wr_badcrc", 1'b0, 9, 5, 1'b0, 2, -1, -1);
    chk("wr_badcrc.final", 0, err, 4'b0001);
    clear_err();
    // Abort in ACTIVE, busy_n three cycles later.
    run_xfer("abort_active", 1'b1, 0, 10, 1'b1, 2, 5, -1);
    chk("abort.final", 0, err, 4'b0100);
    clear_err();
    // Abort coincident with completion: abort wins, CRC not sampled.
    run_xfer("abort_vs_tc", 1'b1, 0, 3, 1'b0, 1, 5, -1);
    clear_err();

    // Conflicting requests in IDLE.
    tx_req = 1'b1; rx_req = 1'b1;
    step();
    drive_idle();
    for (int t = 1; t <= 2; t++) begin
      @(negedge sd_clk);
      chk_all("conflict", t, 2'b00, 1'b0, 1'b0, 1'b0, 4'b1000);
      step();
    end
    clear_err();
    // Set wins over a coincident clear.
    tx_req = 1'b1; rx_req = 1'b1; err_clr = 1'b1;
    step();
    drive_idle();
    @(negedge sd_clk);
    chk("set_over_clr", 0, err, 4'b1000);
    step();
    clear_err();
    // Request while busy is ignored and flagged.
    run_xfer("busy_req", 1'b0, 2, 4, 1'b1, 1, -1, 3);
    chk("busy_req.final", 0, err, 4'b1000);
    clear_err();

    // Reset pulse during ACK.
    rx_req = 1'b1;
    step();
    rx_req = 1'b0;
    step();
    transm_complete = 1'b1; crc_ok = 1'b0;
    step();
    drive_idle();
    @(negedge sd_clk);
    chk_all("pre_rst", 3, 2'b00, 1'b1, 1'b1, 1'b0, 4'b0001);
    #1 rst = 1'b1;
    #1;
    chk_all("mid_rst", 3, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000);
    #1 rst = 1'b0;
    step();
    @(negedge sd_clk);
    chk_all("post_rst", 4, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000);
    step();
    err_model = 4'b0000;
    run_xfer("after_rst", 1'b1, 0, 2, 1'b1, 0, -1, -1);

`ifdef SD_DATA_XFER_TIMEOUT_EN
    // Watchdog: completion never arrives, busy_n stays low.
    timeout = 24'd100;
    rx_req = 1'b1;
    for (int t = 0; t <= 203; t++) begin
      if (t == 1) rx_req = 1'b0;
      @(negedge sd_clk);
      chk_all("watchdog", t,
              (t == 1) ? 2'b10 : ((t >= 101 && t <= 200) ? 2'b11 : 2'b00),
              (t >= 101 && t <= 200), (t >= 1 && t <= 200), (t == 201),
              (t >= 101) ? 4'b0010 : 4'b0000);
      step();
    end
    timeout = 24'd0;
    drive_idle();
    clear_err();
`endif

    // Random transfers against the timeline model.
    for (int i = 0; i < 30; i++) begin
      rd = int'($urandom_range(1, 0));
      fd = int'($urandom_range(4, 0));
      al = int'($urandom_range(6, 0));
      ad = int'($urandom_range(4, 0));
      s = (rd == 1) ? 1 : fd + 2;
      m = s + 1 + al;
      a = ($urandom_range(3, 0) == 0) ? int'($urandom_range(m, 1)) : -1;
      fin = (a >= 0) ? a + 1 + ad : m + 1 + ad;
      stray = ($urandom_range(3, 0) == 0) ? int'($urandom_range(fin, 1)) : -1;
      run_xfer($sformatf("rnd%0d", i), rd == 1, fd, al, ($urandom_range(1, 0) == 1), ad, a, stray);
      if ($urandom_range(1, 0) == 1) clear_err();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
